uart_tx_serial: RTL and testbench
=================================

Name: uart_tx_serial

Overview:
- UART transmit end of the IO-bus UART path. It accepts characters from the bus-side UART register block (uart_io_char/uart_io_we) and from the receiver echo path.
- Characters are buffered in a small FIFO and serialized as 8N1 frames on the TX pin. Bit period is uart_term clock cycles.
- Back-pressure to the bus side is provided through uart_io_full.

Parameters:
- FIFO_DEPTH, 4, number of character entries; must be a power of two, at least 2.
- FIFO_AW, 2, log2(FIFO_DEPTH); pointer width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- uart_io_char  in  8  character from bus-side UART register
- uart_io_we  in  1  one-cycle write strobe for uart_io_char
- uart_io_full  out  1  FIFO full, registered
- uart_term  in  16  clocks per bit
- echo_we  in  1  one-cycle strobe, receiver echo character
- echo_char  in  8  echo character
- uart_tx  out  1  serial TX line, idle high
- tx_busy  out  1  frame in progress or FIFO non-empty
- tx_overflow  out  1  sticky: a character was dropped

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - uart_tx=1, uart_io_full=0, tx_busy=0, tx_overflow=0.
  - FIFO empty; FSM in IDLE; echo holding register empty.
  - Reset mid-frame drives uart_tx high on the next edge; the partial frame is abandoned.
- FIFO:
  - Push sources in priority order: (1) uart_io_we, (2) echo holding register.
  - Pop occurs when the FSM leaves IDLE or STOP to start a frame.
  - Push and pop in the same cycle: count unchanged. A push is accepted even when count==FIFO_DEPTH if a pop occurs that cycle.
- uart_io_full: registered; equals (next count == FIFO_DEPTH).
- Drops:
  - uart_io_we while full with no same-cycle pop: character dropped, tx_overflow set.
  - tx_overflow is cleared only by rst.
- Echo path:
  - echo_we loads a 1-entry holding register.
  - The holding register pushes into the FIFO on the first cycle with no uart_io_we and FIFO not full.
  - echo_we while the holding register is occupied: the new echo is dropped and tx_overflow is set.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_tx=1. If FIFO non-empty, pop into shift register, latch term_lat = max(uart_term,1), and go to START. uart_tx goes low on the edge after the pop cycle, i.e. one cycle after the pop decision.
  - START: uart_tx=0 for term_lat cycles, then DATA with bit_idx=0.
  - DATA: uart_tx = shift[bit_idx], LSB first, each bit held term_lat cycles. After bit 7, go to STOP.
  - STOP: uart_tx=1 for term_lat cycles. On the final cycle, if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Timing:
  - Bit counter is 16 bits, counts 0..term_lat-1, and wraps to 0 on bit advance.
  - uart_term changes mid-frame affect the next frame only.
  - uart_term=0 is treated as 1.
- Frame length: exactly 10*term_lat cycles.
- Latency from uart_io_we (idle, empty FIFO) to falling start edge on uart_tx: 2 cycles (push cycle, pop cycle).
- tx_busy: registered; 1 when the FSM is not IDLE or the FIFO count is non-zero.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3).
  - Frame constants DATA_BITS=8, FRAME_BITS=10.
- One sub-module, uart_tx_fifo: synchronous FIFO with push/pop/count/full/empty and same-cycle push+pop. Parameterized by FIFO_DEPTH/FIFO_AW.
- Echo arbitration and serializer FSM live in uart_tx_serial.

Test Plan:
- Single frame: uart_term=4, write 0x55 at cycle 0 -> uart_tx low on cycles 2-5, then 1,0,1,0,1,0,1,0 each for 4 cycles, stop high for 4 cycles; tx_busy falls at cycle 42.
- Back-to-back: uart_term=2, write 0x00 then 0xFF on consecutive cycles -> stop of frame 1 is immediately followed by start of frame 2 (no idle cycle); 40 cycles total of frame activity.
- Full/overflow: uart_term=100, write 6 chars 0x41..0x46 on consecutive cycles.
  - Expected: first pop frees one slot, so 0x41..0x45 are accepted and 0x46 is dropped.
  - uart_io_full=1 while count==4; tx_overflow=1; transmitted order is 0x41..0x45.
- Echo arbitration: echo_we(0x65) and uart_io_we(0x43) in the same cycle, FIFO empty -> transmit order is 0x43 then 0x65; no overflow.
- uart_term edge cases:
  - uart_term=0 -> each bit lasts 1 cycle (10-cycle frame).
  - uart_term changed from 4 to 8 mid-frame -> current frame keeps 4-cycle bits; next frame uses 8.
- Reset mid-frame: assert rst during DATA bit 3 -> uart_tx=1, uart_io_full=0, tx_busy=0 the next cycle; FIFO empty; a new write then produces a clean frame.

Source files
------------

// File: rtl/uart_tx_serial_pkg.sv
// Shared definitions for the UART transmit path: serializer state encoding,
// frame geometry and the bit-period clamp.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  // A zero bit period would never end a bit, so it is run as one clock.
  function automatic logic [15:0] clamp_term(input logic [15:0] term);
    return (term == 16'd0) ? 16'd1 : term;
  endfunction

endpackage

// File: rtl/uart_tx_serial_if.sv
// Bus-side character write port of the UART transmitter: character, write
// strobe and the registered full flag used as back-pressure.
interface uart_tx_serial_if;

  logic [7:0] uart_io_char;
  logic       uart_io_we;
  logic       uart_io_full;

  modport master (
    output uart_io_char,
    output uart_io_we,
    input  uart_io_full
  );

  modport slave (
    input  uart_io_char,
    input  uart_io_we,
    output uart_io_full
  );

endinterface

// File: rtl/uart_tx_serial_fifo.sv
// Character FIFO for the UART transmitter. A push is accepted while full when
// a pop happens in the same cycle; the full flag is registered.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [7:0]         push_data,
  input  logic               pop,
  output logic [7:0]         pop_data,
  output logic [FIFO_AW:0]   count_next,
  output logic               full,
  output logic               empty
);

  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               push_ok;
  logic               pop_ok;

  assign empty    = (count == '0);
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == (FIFO_AW + 1)'(FIFO_DEPTH));
    end
  end

endmodule

// File: rtl/uart_tx_serial.sv
// UART 8N1 transmitter: arbitrates bus writes against a one-entry echo holding
// register into a FIFO, then serializes characters with a per-frame bit period.
module uart_tx_serial
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_serial_if.slave   io,
  input  logic [15:0]       uart_term,
  input  logic              echo_we,
  input  logic [7:0]        echo_char,
  output logic              uart_tx,
  output logic              tx_busy,
  output logic              tx_overflow
);

  tx_state_t        state, state_next;
  logic [15:0]      cnt, cnt_next;
  logic [15:0]      term_lat, term_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       shift, shift_next;
  logic             pop;
  logic             tx_next;
  logic             bit_end;

  logic             echo_valid;
  logic [7:0]       echo_data;
  logic             echo_push;
  logic             echo_drop;
  logic             io_drop;
  logic             push;
  logic [7:0]       push_data;

  logic [7:0]       fifo_data;
  logic [FIFO_AW:0] fifo_count_next;
  logic             fifo_full;
  logic             fifo_empty;

  // Bus writes always win; the echo character waits for a free cycle.
  assign echo_push = echo_valid && !io.uart_io_we && !fifo_full;
  assign push      = io.uart_io_we || echo_push;
  assign push_data = io.uart_io_we ? io.uart_io_char : echo_data;
  assign io_drop   = io.uart_io_we && fifo_full && !pop;
  assign echo_drop = echo_we && echo_valid && !echo_push;

  assign io.uart_io_full = fifo_full;

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_AW    (FIFO_AW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .pop_data   (fifo_data),
    .count_next (fifo_count_next),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // An echo arriving in the cycle the held one drains into the FIFO replaces it.
  always_ff @(posedge clk) begin
    if (rst) begin
      echo_valid  <= 1'b0;
      echo_data   <= 8'h00;
      tx_overflow <= 1'b0;
    end else begin
      if (echo_we && !echo_drop) begin
        echo_valid <= 1'b1;
        echo_data  <= echo_char;
      end else if (echo_push) begin
        echo_valid <= 1'b0;
      end
      if (io_drop || echo_drop) tx_overflow <= 1'b1;
    end
  end

  assign bit_end = (cnt == term_lat - 16'd1);

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    term_next    = term_lat;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_data;
          term_next  = clamp_term(uart_term);
          cnt_next   = 16'd0;
          state_next = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_next     = 16'd0;
          bit_idx_next = 3'd0;
          state_next   = DATA;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_next = 16'd0;
          if (bit_idx == 3'(DATA_BITS - 1)) state_next = STOP;
          else bit_idx_next = bit_idx + 3'd1;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_next = 16'd0;
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = fifo_data;
            term_next  = clamp_term(uart_term);
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[bit_idx_next];
      default: tx_next = 1'b1;
    endcase
  end

  // Line and busy flag are registered from next-state values so they change
  // on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 16'd0;
      term_lat <= 16'd1;
      bit_idx  <= 3'd0;
      shift    <= 8'h00;
      uart_tx  <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      term_lat <= term_next;
      bit_idx  <= bit_idx_next;
      shift    <= shift_next;
      uart_tx  <= tx_next;
      tx_busy  <= (state_next != IDLE) || (fifo_count_next != '0);
    end
  end

endmodule

// File: tb/tb_uart_tx_serial.sv
// Self-checking bench for uart_tx_serial: per-cycle stimulus tables, a recorded
// line trace decoded into frames and matched against a character scoreboard.
module tb_uart_tx_serial;

  localparam int MAXC = 6000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] uart_term;
  logic        echo_we;
  logic [7:0]  echo_char;
  logic        uart_tx;
  logic        tx_busy;
  logic        tx_overflow;

  uart_tx_serial_if bus ();

  uart_tx_serial #(
    .FIFO_DEPTH (4),
    .FIFO_AW    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .io          (bus),
    .uart_term   (uart_term),
    .echo_we     (echo_we),
    .echo_char   (echo_char),
    .uart_tx     (uart_tx),
    .tx_busy     (tx_busy),
    .tx_overflow (tx_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         term;
  } sb_t;

  typedef struct {
    logic [15:0] term;
    logic [7:0]  data;
    int          exp_start;
    int          exp_busy_fall;
  } vec_t;

  sb_t  sb_q[$];
  int   starts[$];

  logic        tx_tr   [MAXC];
  logic        busy_tr [MAXC];
  logic        full_tr [MAXC];
  logic        ovf_tr  [MAXC];
  logic        wr_v    [MAXC];
  logic [7:0]  wr_d    [MAXC];
  logic        echo_v  [MAXC];
  logic [7:0]  echo_d  [MAXC];
  logic        rst_v   [MAXC];
  logic [15:0] term_v  [MAXC];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic clearStim(input logic [15:0] term);
    for (int c = 0; c < MAXC; c++) begin
      wr_v[c]   = 1'b0;
      wr_d[c]   = 8'h00;
      echo_v[c] = 1'b0;
      echo_d[c] = 8'h00;
      rst_v[c]  = 1'b0;
      term_v[c] = term;
    end
    sb_q.delete();
    starts.delete();
    uart_term = term;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1;
    bus.uart_io_we = 1'b0;
    echo_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Cycle c: outputs are recorded mid-cycle, inputs for c are driven then.
  task automatic applyStimulus(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      tx_tr[c]         = uart_tx;
      busy_tr[c]       = tx_busy;
      full_tr[c]       = bus.uart_io_full;
      ovf_tr[c]        = tx_overflow;
      bus.uart_io_we   = wr_v[c];
      bus.uart_io_char = wr_d[c];
      echo_we          = echo_v[c];
      echo_char        = echo_d[c];
      rst              = rst_v[c];
      uart_term        = term_v[c];
    end
    @(negedge clk);
    bus.uart_io_we = 1'b0;
    echo_we        = 1'b0;
    rst            = 1'b0;
  endtask

  task automatic decodeFrames(input int from, input int n, input string tag);
    int         i;
    int         t;
    sb_t        e;
    logic [7:0] rx;
    logic       exp_bit;
    logic       shape_ok;
    i = from;
    while (i < n) begin
      if (tx_tr[i] === 1'b0 && (i == 0 || tx_tr[i-1] === 1'b1)) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("[TB] FAIL %s unexpected frame: start at cycle %0d, required none", tag, i);
          break;
        end
        e = sb_q.pop_front();
        t = (e.term < 1) ? 1 : e.term;
        starts.push_back(i);
        if (i + 10 * t > n) begin
          n_checks++;
          $display("[TB] FAIL %s truncated frame: start %0d, required end by %0d", tag, i, n);
          break;
        end
        shape_ok = 1'b1;
        rx = 8'h00;
        for (int k = 0; k < 10; k++) begin
          exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : e.data[k-1];
          for (int j = 0; j < t; j++)
            if (tx_tr[i + k * t + j] !== exp_bit) shape_ok = 1'b0;
          if (k >= 1 && k <= 8) rx[k-1] = tx_tr[i + k * t + t / 2];
        end
        checkOutput({tag, " frame data"}, 32'(rx), 32'(e.data));
        checkOutput({tag, " frame timing"}, 32'(shape_ok), 32'd1);
        i += 10 * t;
      end else begin
        i++;
      end
    end
    checkOutput({tag, " frames pending"}, 32'(sb_q.size()), 32'd0);
  endtask

  function automatic int firstStart(input int idx);
    return (starts.size() > idx) ? starts[idx] : -1;
  endfunction

  vec_t vecs[5];
  logic all_high;
  int   run_len;

  initial begin
    vecs[0] = '{16'd4, 8'h55, 2, 42};
    vecs[1] = '{16'd0, 8'hA3, 2, 12};
    vecs[2] = '{16'd1, 8'h01, 2, 12};
    vecs[3] = '{16'd3, 8'h80, 2, 32};
    vecs[4] = '{16'd7, 8'hE6, 2, 72};

    rst = 1'b1;
    bus.uart_io_we = 1'b0;
    bus.uart_io_char = 8'h00;
    echo_we = 1'b0;
    echo_char = 8'h00;
    uart_term = 16'd4;
    repeat (3) @(negedge clk);
    checkOutput("reset uart_tx", 32'(uart_tx), 32'd1);
    checkOutput("reset tx_busy", 32'(tx_busy), 32'd0);
    checkOutput("reset uart_io_full", 32'(bus.uart_io_full), 32'd0);
    checkOutput("reset tx_overflow", 32'(tx_overflow), 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      clearStim(vecs[v].term);
      resetDut();
      wr_v[0] = 1'b1;
      wr_d[0] = vecs[v].data;
      sb_q.push_back('{vecs[v].data, int'(vecs[v].term)});
      run_len = vecs[v].exp_busy_fall + 6;
      applyStimulus(run_len);
      decodeFrames(0, run_len, $sformatf("vec%0d", v));
      checkOutput($sformatf("vec%0d start cycle", v), 32'(firstStart(0)), 32'(vecs[v].exp_start));
      checkOutput($sformatf("vec%0d line before start", v), 32'(tx_tr[1]), 32'd1);
      checkOutput($sformatf("vec%0d busy after push", v), 32'(busy_tr[1]), 32'd1);
      checkOutput($sformatf("vec%0d busy last", v), 32'(busy_tr[vecs[v].exp_busy_fall - 1]), 32'd1);
      checkOutput($sformatf("vec%0d busy fall", v), 32'(busy_tr[vecs[v].exp_busy_fall]), 32'd0);
      checkOutput($sformatf("vec%0d overflow", v), 32'(ovf_tr[run_len - 1]), 32'd0);
    end

    // Back-to-back frames: stop of frame 1 runs straight into start of frame 2.
    clearStim(16'd2);
    resetDut();
    wr_v[0] = 1'b1; wr_d[0] = 8'h00;
    wr_v[1] = 1'b1; wr_d[1] = 8'hFF;
    sb_q.push_back('{8'h00, 2});
    sb_q.push_back('{8'hFF, 2});
    applyStimulus(48);
    decodeFrames(0, 48, "b2b");
    checkOutput("b2b start1", 32'(firstStart(0)), 32'd2);
    checkOutput("b2b start2", 32'(firstStart(1)), 32'd22);
    checkOutput("b2b busy last", 32'(busy_tr[41]), 32'd1);
    checkOutput("b2b busy fall", 32'(busy_tr[42]), 32'd0);

    // Six writes into a four-deep FIFO while the first frame is starting.
    clearStim(16'd100);
    resetDut();
    for (int c = 0; c < 6; c++) begin
      wr_v[c] = 1'b1;
      wr_d[c] = 8'h41 + 8'(c);
      if (c < 5) sb_q.push_back('{8'h41 + 8'(c), 100});
    end
    applyStimulus(5010);
    decodeFrames(0, 5010, "ovf");
    checkOutput("ovf full c4", 32'(full_tr[4]), 32'd0);
    checkOutput("ovf full c5", 32'(full_tr[5]), 32'd1);
    checkOutput("ovf full before pop", 32'(full_tr[1001]), 32'd1);
    checkOutput("ovf full after pop", 32'(full_tr[1002]), 32'd0);
    checkOutput("ovf flag c5", 32'(ovf_tr[5]), 32'd0);
    checkOutput("ovf flag c6", 32'(ovf_tr[6]), 32'd1);
    checkOutput("ovf flag sticky", 32'(ovf_tr[5009]), 32'd1);
    checkOutput("ovf busy fall", 32'(busy_tr[5002]), 32'd0);

    // Echo and bus write in the same cycle: bus character goes first.
    clearStim(16'd2);
    resetDut();
    wr_v[0] = 1'b1; wr_d[0] = 8'h43;
    echo_v[0] = 1'b1; echo_d[0] = 8'h65;
    sb_q.push_back('{8'h43, 2});
    sb_q.push_back('{8'h65, 2});
    applyStimulus(50);
    decodeFrames(0, 50, "echo");
    checkOutput("echo start2", 32'(firstStart(1)), 32'd22);
    checkOutput("echo overflow", 32'(ovf_tr[49]), 32'd0);

    // Second echo while the held one is still blocked by bus writes is dropped.
    clearStim(16'd1);
    resetDut();
    for (int c = 0; c < 3; c++) begin
      wr_v[c] = 1'b1;
      wr_d[c] = 8'hA0 + 8'(c);
      sb_q.push_back('{8'hA0 + 8'(c), 1});
    end
    echo_v[0] = 1'b1; echo_d[0] = 8'h11;
    echo_v[1] = 1'b1; echo_d[1] = 8'h22;
    sb_q.push_back('{8'h11, 1});
    applyStimulus(50);
    decodeFrames(0, 50, "echodrop");
    checkOutput("echodrop flag c1", 32'(ovf_tr[1]), 32'd0);
    checkOutput("echodrop flag c2", 32'(ovf_tr[2]), 32'd1);

    // Bit period change mid-frame only affects the following frame.
    clearStim(16'd4);
    resetDut();
    for (int c = 10; c < MAXC; c++) term_v[c] = 16'd8;
    wr_v[0] = 1'b1; wr_d[0] = 8'h3C;
    wr_v[1] = 1'b1; wr_d[1] = 8'hC3;
    sb_q.push_back('{8'h3C, 4});
    sb_q.push_back('{8'hC3, 8});
    applyStimulus(130);
    decodeFrames(0, 130, "term");
    checkOutput("term start2", 32'(firstStart(1)), 32'd42);
    checkOutput("term busy last", 32'(busy_tr[121]), 32'd1);
    checkOutput("term busy fall", 32'(busy_tr[122]), 32'd0);

    // Reset during data bit 3 abandons the frame and empties the FIFO.
    clearStim(16'd4);
    resetDut();
    wr_v[0] = 1'b1; wr_d[0] = 8'hF0;
    wr_v[1] = 1'b1; wr_d[1] = 8'h11;
    wr_v[2] = 1'b1; wr_d[2] = 8'h22;
    rst_v[19] = 1'b1;
    wr_v[40] = 1'b1; wr_d[40] = 8'h96;
    sb_q.push_back('{8'h96, 4});
    applyStimulus(90);
    checkOutput("rst line during bit3", 32'(tx_tr[19]), 32'd0);
    checkOutput("rst line after", 32'(tx_tr[20]), 32'd1);
    checkOutput("rst busy after", 32'(busy_tr[20]), 32'd0);
    checkOutput("rst full after", 32'(full_tr[20]), 32'd0);
    all_high = 1'b1;
    for (int c = 20; c < 42; c++) if (tx_tr[c] !== 1'b1) all_high = 1'b0;
    checkOutput("rst line idle", 32'(all_high), 32'd1);
    checkOutput("rst busy idle", 32'(busy_tr[40]), 32'd0);
    decodeFrames(30, 90, "rst");
    checkOutput("rst new start", 32'(firstStart(0)), 32'd42);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
